butterfly_inverse: RTL and testbench
====================================

// Module: butterfly_inverse
// PURPOSE
//  Pipelined radix-2 inverse (Gentleman-Sande / DIF) butterfly, the return path for the forward
//  butterfly_sum stage: A' = A + B, B' = (A - B) * conj(W). Operates on the same packed complex
//  word {real[HALF-1:0], imag[HALF-1:0]}, two's complement, with valid/ready flow control.
//  Sits between IFFT stage memories; one butterfly accepted per cycle when not stalled.
// PARAMETERS
//  WORD_SIZE  74  packed complex word width (2*HALF_SIZE)
//  HALF_SIZE  37  width of each signed real/imag component
//  FRAC_BITS  30  fractional bits of twiddle components (1.0 = 2^30)
// PORTS
//  i_CLK      in   1          clock, rising edge
//  i_RST      in   1          async reset, active-low
//  i_valid    in   1          input butterfly valid
//  o_ready    out  1          block can accept input this cycle
//  i_A        in   WORD_SIZE  operand A, packed complex
//  i_B        in   WORD_SIZE  operand B, packed complex
//  i_twiddle  in   WORD_SIZE  twiddle W, packed complex, Q(HALF_SIZE-FRAC_BITS).FRAC_BITS
//  o_valid    out  1          output pair valid
//  i_ready    in   1          downstream accepts output
//  o_A        out  WORD_SIZE  A' result, packed complex
//  o_B        out  WORD_SIZE  B' result, packed complex
//  i_sat_clr  in   1          synchronous clear of o_sat
//  o_sat      out  1          sticky: any component saturated since reset/clear
// BEHAVIOUR
//  Reset (i_RST=0, async): all stage valids 0, o_valid=0, o_A=o_B=0, o_sat=0; data regs 0.
//  Pipeline: S1 add/sub, S2 complex multiply + round/saturate, S3 output reg. Latency 3 cycles
//   from input handshake (i_valid & o_ready) to o_valid, with i_ready held high.
//  Stage k loads when stage k+1 is empty or advancing; S3 advances when !o_valid | i_ready.
//   o_ready = S1 empty or advancing (combinational from i_ready; bubbles collapse).
//  Stall: with i_ready=0, o_A/o_B/o_valid held stable; up to 3 items stored, none dropped/duplicated.
//  S1: sum = A+B, diff = A-B per component, HALF_SIZE+1 bits, no loss.
//  S2: Br = dr*wr + di*wi; Bi = di*wr - dr*wi (full-width products and sum);
//   round half-up: add 2^(FRAC_BITS-1), arithmetic shift right FRAC_BITS.
//  Saturation: every final component clamps to [-2^(HALF_SIZE-1), 2^(HALF_SIZE-1)-1];
//   any clamp on an item that completes S2 sets o_sat next cycle.
//  o_sat: set has priority over i_sat_clr in the same cycle.
//  Twiddle -1.0 in both components is legal; conj(W) is computed in the multiply, not by negation.
//  Reset mid-operation: in-flight items discarded, no partial output after release.
//  i_valid with o_ready=0: input not taken; source must hold i_A/i_B/i_twiddle stable.
// CONFIGURATION
//  BFLY_INV_SCALE_EN defined: both A' and B' components scaled by 1/2 (add 1, arithmetic
//   shift right 1, round half-up) before saturation; intended for per-stage IFFT 1/N scaling.
//   Latency unchanged.
//  Not defined: no scaling; growth handled by saturation only.
// TESTING
//  1 W=(2^30,0), A=(3,4), B=(1,2) -> 3 cycles later o_A=(4,6), o_B=(2,2), o_sat=0.
//  2 W=(0,2^30), A=(3,4), B=(1,2) -> o_B=(2,-2); W=(-2^30,0) -> o_B=(-2,-2).
//  3 A.real=2^36-1, B.real=1, W=(2^30,0) -> o_A.real=2^36-1, o_sat=1 until i_sat_clr pulse.
//  4 Stream 8 items, i_ready=0 for cycles 3-6 -> o_ready low once 3 held,
//    all 8 out in order, o_A/o_B stable while stalled.
//  5 i_RST low with 2 items in flight -> o_valid=0, o_A=o_B=0, o_sat=0 immediately, no output after.
//  6 BFLY_INV_SCALE_EN, test 1 stimulus -> o_A=(2,3), o_B=(1,1); A=(3,0),B=(0,0) -> o_A.real=2.

Source files
------------

// File: rtl/butterfly_inverse.sv
// butterfly_inverse: 3-stage pipelined radix-2 DIF inverse butterfly, A' = A + B, B' = (A - B) * conj(W).
// Define BFLY_INV_SCALE_EN to halve both results (round half-up) ahead of saturation.
module butterfly_inverse #(
    parameter int WORD_SIZE = 74,
    parameter int HALF_SIZE = 37,
    parameter int FRAC_BITS = 30
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WORD_SIZE-1:0] i_A,
    input  logic [WORD_SIZE-1:0] i_B,
    input  logic [WORD_SIZE-1:0] i_twiddle,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] o_A,
    output logic [WORD_SIZE-1:0] o_B,
    input  logic                 i_sat_clr,
    output logic                 o_sat
);

    localparam int SW = HALF_SIZE + 1;
    localparam int EW = 2 * HALF_SIZE + 4;
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] RND  = ONE <<< (FRAC_BITS - 1);
    localparam logic signed [EW-1:0] MAXV = (ONE <<< (HALF_SIZE - 1)) - ONE;
    localparam logic signed [EW-1:0] MINV = -(ONE <<< (HALF_SIZE - 1));

    // Handshake: a word moves on a rising edge where valid and ready are both high; the sender
    // keeps valid and data stable until then. A stage loads when the next one is empty or
    // emptying, so bubbles collapse and all three stages can hold an item under backpressure.
    logic ld1, ld2, ld3;
    logic v1_q, v2_q, v3_q, sat_q, sat_d, clamp2;
    logic signed [SW-1:0] sr_q, si_q, dr_q, di_q;
    logic signed [SW-1:0] sr_d, si_d, dr_d, di_d;
    logic [WORD_SIZE-1:0] w_q, a2_q, b2_q, a2_d, b2_d, oa_q, ob_q;
    logic signed [HALF_SIZE-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [EW-1:0] pr, pi;
    logic [HALF_SIZE:0] qar, qai, qbr, qbi;

    function automatic logic signed [EW-1:0] ext_s(input logic signed [SW-1:0] x);
        return {{(EW-SW){x[SW-1]}}, x};
    endfunction

    function automatic logic signed [EW-1:0] ext_h(input logic signed [HALF_SIZE-1:0] x);
        return {{(EW-HALF_SIZE){x[HALF_SIZE-1]}}, x};
    endfunction

    function automatic logic signed [EW-1:0] scale(input logic signed [EW-1:0] x);
`ifdef BFLY_INV_SCALE_EN
        return (x + ONE) >>> 1;
`else
        return x;
`endif
    endfunction

    // Returns {clamped_flag, value} with value limited to the signed HALF_SIZE range.
    function automatic logic [HALF_SIZE:0] sat_fn(input logic signed [EW-1:0] x);
        logic [HALF_SIZE:0] r;
        if (x > MAXV)      r = {1'b1, MAXV[HALF_SIZE-1:0]};
        else if (x < MINV) r = {1'b1, MINV[HALF_SIZE-1:0]};
        else               r = {1'b0, x[HALF_SIZE-1:0]};
        return r;
    endfunction

    always_comb begin
        ld3     = !v3_q || i_ready;
        ld2     = !v2_q || ld3;
        ld1     = !v1_q || ld2;
        o_ready = ld1;
    end

    always_comb begin
        a_re = i_A[WORD_SIZE-1:HALF_SIZE];
        a_im = i_A[HALF_SIZE-1:0];
        b_re = i_B[WORD_SIZE-1:HALF_SIZE];
        b_im = i_B[HALF_SIZE-1:0];
        sr_d = {a_re[HALF_SIZE-1], a_re} + {b_re[HALF_SIZE-1], b_re};
        si_d = {a_im[HALF_SIZE-1], a_im} + {b_im[HALF_SIZE-1], b_im};
        dr_d = {a_re[HALF_SIZE-1], a_re} - {b_re[HALF_SIZE-1], b_re};
        di_d = {a_im[HALF_SIZE-1], a_im} - {b_im[HALF_SIZE-1], b_im};
    end

    // conj(W) is folded into the cross-term signs, so a -1.0 twiddle never needs negating.
    always_comb begin
        w_re   = w_q[WORD_SIZE-1:HALF_SIZE];
        w_im   = w_q[HALF_SIZE-1:0];
        pr     = ext_s(dr_q) * ext_h(w_re) + ext_s(di_q) * ext_h(w_im);
        pi     = ext_s(di_q) * ext_h(w_re) - ext_s(dr_q) * ext_h(w_im);
        qar    = sat_fn(scale(ext_s(sr_q)));
        qai    = sat_fn(scale(ext_s(si_q)));
        qbr    = sat_fn(scale((pr + RND) >>> FRAC_BITS));
        qbi    = sat_fn(scale((pi + RND) >>> FRAC_BITS));
        a2_d   = {qar[HALF_SIZE-1:0], qai[HALF_SIZE-1:0]};
        b2_d   = {qbr[HALF_SIZE-1:0], qbi[HALF_SIZE-1:0]};
        clamp2 = qar[HALF_SIZE] | qai[HALF_SIZE] | qbr[HALF_SIZE] | qbi[HALF_SIZE];
        sat_d  = sat_q;
        if (v1_q && ld2 && clamp2) sat_d = 1'b1;
        else if (i_sat_clr)        sat_d = 1'b0;
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            sat_q <= 1'b0;
            sr_q  <= '0;
            si_q  <= '0;
            dr_q  <= '0;
            di_q  <= '0;
            w_q   <= '0;
            a2_q  <= '0;
            b2_q  <= '0;
            oa_q  <= '0;
            ob_q  <= '0;
        end else begin
            if (ld1) begin
                v1_q <= i_valid;
                if (i_valid) begin
                    sr_q <= sr_d;
                    si_q <= si_d;
                    dr_q <= dr_d;
                    di_q <= di_d;
                    w_q  <= i_twiddle;
                end
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    a2_q <= a2_d;
                    b2_q <= b2_d;
                end
            end
            if (ld3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    oa_q <= a2_q;
                    ob_q <= b2_q;
                end
            end
            sat_q <= sat_d;
        end
    end

    assign o_valid = v3_q;
    assign o_A     = oa_q;
    assign o_B     = ob_q;
    assign o_sat   = sat_q;

endmodule

// File: tb/tb_butterfly_inverse.sv
// Self-checking bench for butterfly_inverse: directed cases plus randomized streams scored
// against a wide-integer reference model of the butterfly equations.
module tb_butterfly_inverse;

    localparam int W = 74;
    localparam int H = 37;
    localparam int F = 30;
    localparam longint P30 = 64'sd1073741824;
    localparam longint P36 = 64'sd68719476736;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [W-1:0] i_A = '0;
    logic [W-1:0] i_B = '0;
    logic [W-1:0] i_tw = '0;
    logic         o_valid;
    logic         i_ready = 1'b1;
    logic [W-1:0] o_A, o_B;
    logic         i_sat_clr = 1'b0;
    logic         o_sat;

    int total = 0;
    int bad = 0;
    int n_out = 0;
    bit mdl_sat = 1'b0;
    bit saw_busy;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0] sa[64], sb[64], sw[64];

    butterfly_inverse dut (
        .i_CLK(clk), .i_RST(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_A(i_A), .i_B(i_B), .i_twiddle(i_tw), .o_valid(o_valid), .i_ready(i_ready),
        .o_A(o_A), .o_B(o_B), .i_sat_clr(i_sat_clr), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pk(input longint re, input longint im);
        logic [H-1:0] r, i;
        r = H'(re);
        i = H'(im);
        return {r, i};
    endfunction

    function automatic logic [H:0] clampv(input logic signed [127:0] v);
        logic signed [127:0] mx, mn;
        mx = (128'sd1 <<< (H - 1)) - 128'sd1;
        mn = -(128'sd1 <<< (H - 1));
        if (v > mx) return {1'b1, mx[H-1:0]};
        if (v < mn) return {1'b1, mn[H-1:0]};
        return {1'b0, v[H-1:0]};
    endfunction

    // Reference: returns {any_clamp, A', B'} computed with unbounded-width integers.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] w);
        logic signed [127:0] ar, ai, br, bi, wr, wi, dr, di;
        logic signed [127:0] s[4];
        logic [H:0] c[4];
        ar = 128'($signed(a[W-1:H]));
        ai = 128'($signed(a[H-1:0]));
        br = 128'($signed(b[W-1:H]));
        bi = 128'($signed(b[H-1:0]));
        wr = 128'($signed(w[W-1:H]));
        wi = 128'($signed(w[H-1:0]));
        dr = ar - br;
        di = ai - bi;
        s[0] = ar + br;
        s[1] = ai + bi;
        s[2] = (dr * wr + di * wi + (128'sd1 <<< (F - 1))) >>> F;
        s[3] = (di * wr - dr * wi + (128'sd1 <<< (F - 1))) >>> F;
        for (int k = 0; k < 4; k++) begin
`ifdef BFLY_INV_SCALE_EN
            s[k] = (s[k] + 128'sd1) >>> 1;
`endif
            c[k] = clampv(s[k]);
        end
        return {c[0][H] | c[1][H] | c[2][H] | c[3][H],
                c[0][H-1:0], c[1][H-1:0], c[2][H-1:0], c[3][H-1:0]};
    endfunction

    function automatic logic [H-1:0] rcomp(input bit big);
        longint t;
        if (big) t = {$urandom, $urandom};
        else     t = longint'($urandom_range(0, 2097152)) - 64'sd1048576;
        return H'(t);
    endfunction

    function automatic logic [H-1:0] rtw(input bit big);
        longint t;
        if (big) t = {$urandom, $urandom};
        else     t = longint'($urandom_range(0, 32'h8000_0000)) - P30;
        return H'(t);
    endfunction

    task automatic gen_items(input int n);
        bit big;
        for (int k = 0; k < n; k++) begin
            big   = ($urandom_range(0, 3) == 0);
            sa[k] = {rcomp(big), rcomp(big)};
            sb[k] = {rcomp(big), rcomp(big)};
            sw[k] = {rtw(big), rtw(big)};
        end
    endtask

    // Scoreboard monitor: records accepted inputs, checks outputs in order and hold-under-stall.
    logic [2*W:0]   mres;
    logic [2*W-1:0] mexp;
    logic           prev_stall = 1'b0;
    logic [W-1:0]   prev_a, prev_b;

    always @(negedge clk) begin
        if (rst_n) begin
            if (i_valid && o_ready) begin
                mres = model(i_A, i_B, i_tw);
                exp_q.push_back(mres[2*W-1:0]);
                if (mres[2*W]) mdl_sat = 1'b1;
            end
            if (prev_stall) begin
                total++;
                assert (o_valid === 1'b1 && o_A === prev_a && o_B === prev_b) else begin
                    bad++;
                    $error("FAIL stall_hold got v=%0b A=%0h B=%0h exp v=1 A=%0h B=%0h",
                           o_valid, o_A, o_B, prev_a, prev_b);
                end
            end
            if (o_valid && i_ready) begin
                n_out++;
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL unexpected_out got A=%0h B=%0h exp none", o_A, o_B);
                end
                if (exp_q.size() > 0) begin
                    mexp = exp_q.pop_front();
                    total++;
                    assert ({o_A, o_B} === mexp) else begin
                        bad++;
                        $error("FAIL out_data got A=%0h B=%0h exp A=%0h B=%0h",
                               o_A, o_B, mexp[2*W-1:W], mexp[W-1:0]);
                    end
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_a     = o_A;
            prev_b     = o_B;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sends one item into an idle pipeline and waits for it at the output.
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] w);
        int lat;
        i_ready = 1'b1;
        i_A = a;
        i_B = b;
        i_tw = w;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", 128'(lat), 128'd3);
    endtask

    // mode 0: always ready, 1: ready low for loop cycles 3..6, 2: random ready.
    task automatic run_stream(input int n, input int mode);
        int idx, cyc, out0;
        idx = 0;
        cyc = 0;
        out0 = n_out;
        saw_busy = 1'b0;
        while ((idx < n || n_out - out0 < n) && cyc < 600) begin
            case (mode)
                0:       i_ready = 1'b1;
                1:       i_ready = !(cyc >= 3 && cyc <= 6);
                default: i_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (idx < n) begin
                i_valid = 1'b1;
                i_A = sa[idx];
                i_B = sb[idx];
                i_tw = sw[idx];
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            if (i_valid && !o_ready) saw_busy = 1'b1;
            if (i_valid && o_ready) idx++;
            tick();
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("stream_count", 128'(n_out - out0), 128'(n));
        check("stream_queue_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        logic [W-1:0] sat_a, sat_b, sat_w;
        int out0;
        sat_a = pk(-P36, -P36);
        sat_b = pk(P36 - 1, P36 - 1);
        sat_w = pk(-P30, -P30);

        // reset state
        tick();
        tick();
        check("rst_valid", 128'(o_valid), 128'd0);
        check("rst_oA", 128'(o_A), 128'd0);
        check("rst_oB", 128'(o_B), 128'd0);
        check("rst_sat", 128'(o_sat), 128'd0);
        check("rst_ready", 128'(o_ready), 128'd1);
        rst_n = 1'b1;
        tick();

        // identity twiddle
        send_one(pk(3, 4), pk(1, 2), pk(P30, 0));
`ifdef BFLY_INV_SCALE_EN
        check("t1_oA", 128'(o_A), 128'(pk(2, 3)));
        check("t1_oB", 128'(o_B), 128'(pk(1, 1)));
`else
        check("t1_oA", 128'(o_A), 128'(pk(4, 6)));
        check("t1_oB", 128'(o_B), 128'(pk(2, 2)));
`endif
        check("t1_sat", 128'(o_sat), 128'd0);
        tick();

        // twiddle j and -1
        send_one(pk(3, 4), pk(1, 2), pk(0, P30));
`ifdef BFLY_INV_SCALE_EN
        check("t2_oB_j", 128'(o_B), 128'(pk(1, -1)));
`else
        check("t2_oB_j", 128'(o_B), 128'(pk(2, -2)));
`endif
        tick();
        send_one(pk(3, 4), pk(1, 2), pk(-P30, 0));
`ifdef BFLY_INV_SCALE_EN
        check("t2_oB_m1", 128'(o_B), 128'(pk(-1, -1)));
`else
        check("t2_oB_m1", 128'(o_B), 128'(pk(-2, -2)));
`endif
        tick();

        // half-up rounding of an odd sum
        send_one(pk(3, 0), pk(0, 0), pk(P30, 0));
`ifdef BFLY_INV_SCALE_EN
        check("t6_oA_re", 128'(o_A[W-1:H]), 128'd2);
`else
        check("t6_oA_re", 128'(o_A[W-1:H]), 128'd3);
`endif
        tick();

        // positive overflow of A'
        send_one(pk(P36 - 1, 0), pk(1, 0), pk(P30, 0));
`ifdef BFLY_INV_SCALE_EN
        check("t3_oA_re", 128'(o_A[W-1:H]), 128'(H'(P36 / 2)));
        check("t3_sat", 128'(o_sat), 128'd0);
`else
        check("t3_oA_re", 128'(o_A[W-1:H]), 128'(H'(P36 - 1)));
        check("t3_sat", 128'(o_sat), 128'd1);
`endif
        tick();

        // overflow of B' under a -1-1j twiddle, clamps in both builds
        send_one(sat_a, sat_b, sat_w);
        check("t3b_oB_re", 128'(o_B[W-1:H]), 128'(H'(P36 - 1)));
        check("t3b_sat", 128'(o_sat), 128'd1);
        tick();
        tick();
        check("sat_sticky", 128'(o_sat), 128'd1);
        i_sat_clr = 1'b1;
        tick();
        i_sat_clr = 1'b0;
        check("sat_clear", 128'(o_sat), 128'd0);

        // clear coinciding with a new clamp: the set must win
        i_A = sat_a;
        i_B = sat_b;
        i_tw = sat_w;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_sat_clr = 1'b1;
        tick();
        i_sat_clr = 1'b0;
        check("sat_set_wins", 128'(o_sat), 128'd1);
        repeat (3) tick();
        i_sat_clr = 1'b1;
        tick();
        i_sat_clr = 1'b0;
        mdl_sat = 1'b0;

        // 8-item stream with a 4-cycle downstream stall
        gen_items(8);
        run_stream(8, 1);
        check("t4_busy_seen", 128'(saw_busy), 128'd1);

        // reset with two items in flight
        i_A = sat_a;
        i_B = sat_b;
        i_tw = sat_w;
        i_valid = 1'b1;
        tick();
        i_A = pk(5, 6);
        i_B = pk(1, 1);
        i_tw = pk(P30, 0);
        tick();
        i_valid = 1'b0;
        check("t5_sat_before", 128'(o_sat), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        mdl_sat = 1'b0;
        check("t5_valid", 128'(o_valid), 128'd0);
        check("t5_oA", 128'(o_A), 128'd0);
        check("t5_oB", 128'(o_B), 128'd0);
        check("t5_sat", 128'(o_sat), 128'd0);
        tick();
        rst_n = 1'b1;
        out0 = n_out;
        repeat (6) tick();
        check("t5_no_output", 128'(n_out - out0), 128'd0);
        check("t5_valid_after", 128'(o_valid), 128'd0);

        // randomized streams, full throughput then random backpressure
        gen_items(30);
        run_stream(30, 0);
        gen_items(50);
        run_stream(50, 2);
        repeat (2) tick();
        check("rand_sat", 128'(o_sat), 128'(mdl_sat));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
